// File: rtl/wt_dcache_miss_arb_pkg.sv
`default_nettype none
// ============================================================================
// Packages: config_pkg, wt_cache_pkg, wt_dcache_miss_arb_pkg
// Core config, shared miss-request record and arbiter-local types.
// Revision: 1.0
// ============================================================================

package config_pkg;
    typedef struct packed {
        int unsigned PLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 32'd0};
endpackage

package wt_cache_pkg;
    localparam int unsigned PLEN           = 56;
    localparam int unsigned SET_ASSOC      = 4;
    localparam int unsigned CACHE_ID_WIDTH = 4;

    typedef struct packed {
        logic [PLEN-1:0]           paddr;
        logic [2:0]                size;
        logic                      nc;
        logic [SET_ASSOC-1:0]      vld_bits;
        logic [CACHE_ID_WIDTH-1:0] id;
    } miss_req_t;
endpackage

package wt_dcache_miss_arb_pkg;
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction
endpackage

`default_nettype wire

// File: rtl/wt_dcache_miss_arb_if.sv
`default_nettype none
// ============================================================================
// Interface: wt_dcache_miss_arb_if
// Arbiter <-> miss-unit request/response bus.
// Revision: 1.0
// ============================================================================

interface wt_dcache_miss_arb_if;
    import wt_cache_pkg::*;

    logic                      mu_req;
    miss_req_t                 mu_req_data;
    logic                      mu_ack;
    logic                      mu_replay;
    logic                      mu_rtrn_vld;
    logic [CACHE_ID_WIDTH-1:0] mu_rtrn_id;

    modport master (
        output mu_req, mu_req_data,
        input  mu_ack, mu_replay, mu_rtrn_vld, mu_rtrn_id
    );

    modport slave (
        input  mu_req, mu_req_data,
        output mu_ack, mu_replay, mu_rtrn_vld, mu_rtrn_id
    );
endinterface

`default_nettype wire

// File: rtl/wt_dcache_miss_rr.sv
`default_nettype none
// ============================================================================
// Module: wt_dcache_miss_rr
// Picks the first requester at or after ptr, wrapping around NumPorts.
// Revision: 1.0
// ============================================================================

module wt_dcache_miss_rr #(
    parameter int unsigned NumPorts = 3
) (
    input  logic [NumPorts-1:0]                                 req,
    input  logic [((NumPorts > 1) ? $clog2(NumPorts) : 1)-1:0] ptr,
    output logic [((NumPorts > 1) ? $clog2(NumPorts) : 1)-1:0] idx,
    output logic                                                valid
);
    localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx   = '0;
        valid = |req;
        sum   = '0;
        cand  = '0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IdxW+1)'(k);
            if (sum >= (IdxW+1)'(NumPorts)) begin
                sum = sum - (IdxW+1)'(NumPorts);
            end
            cand = sum[IdxW-1:0];
            if (req[cand]) begin
                idx = cand;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/wt_dcache_miss_arb.sv
`default_nettype none
// ============================================================================
// Module: wt_dcache_miss_arb
// Round-robin arbiter of dcache read-controller misses onto one miss unit.
// Revision: 1.0
// ============================================================================

module wt_dcache_miss_arb
    import wt_cache_pkg::*;
    import wt_dcache_miss_arb_pkg::*;
#(
    parameter int unsigned          NumPorts = 3,
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumPorts-1:0]   miss_req_i,
    input  miss_req_t             miss_req_data_i [NumPorts],
    output logic [NumPorts-1:0]   miss_ack_o,
    output logic [NumPorts-1:0]   miss_replay_o,
    output logic [NumPorts-1:0]   miss_rtrn_vld_o,
    wt_dcache_miss_arb_if.master  mu
);
    localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    // A core with a narrower physical address space drops the upper paddr bits.
    localparam int unsigned PlenEff =
        (CVA6Cfg.PLEN == 0 || CVA6Cfg.PLEN > PLEN) ? PLEN : CVA6Cfg.PLEN;
    localparam logic [PLEN-1:0] PaddrMask = {PLEN{1'b1}} >> (PLEN - PlenEff);

    arb_state_e            state_q, state_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NumPorts-1:0]   outstanding_q, outstanding_d;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_valid;
    logic [IdxW-1:0]       owner_next;

    wt_dcache_miss_rr #(.NumPorts(NumPorts)) i_rr (
        .req   (miss_req_i),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_next = IdxW'(wrap_inc(32'(owner_q), NumPorts));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Replay outranks ack; a withdrawn request ignores both.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        miss_ack_o    = '0;
        miss_replay_o = '0;
        mu.mu_req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!miss_req_i[owner_q]) begin
                    state_d = IDLE;
                end else begin
                    mu.mu_req = 1'b1;
                    if (mu.mu_replay) begin
                        miss_replay_o[owner_q] = 1'b1;
                        rr_ptr_d               = owner_next;
                        state_d                = IDLE;
                    end else if (mu.mu_ack) begin
                        miss_ack_o[owner_q] = 1'b1;
                        rr_ptr_d            = owner_next;
                        state_d             = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mu.mu_req_data = '0;
        if (state_q == BUSY) begin
            mu.mu_req_data       = miss_req_data_i[owner_q];
            mu.mu_req_data.paddr = miss_req_data_i[owner_q].paddr & PaddrMask;
        end
    end

    always_comb begin
        miss_rtrn_vld_o = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            miss_rtrn_vld_o[p] = mu.mu_rtrn_vld & outstanding_q[p]
                               & (mu.mu_rtrn_id == miss_req_data_i[p].id);
        end
    end

    // A fresh acceptance on the same port keeps it outstanding over a return.
    assign outstanding_d = (outstanding_q & ~miss_rtrn_vld_o) | miss_ack_o;

    a_no_ack_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (miss_ack_o & outstanding_q & ~miss_rtrn_vld_o) == '0)
        else $fatal(1, "miss ack to a port with a miss still outstanding");

    a_req_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mu.mu_req && !mu.mu_ack && !mu.mu_replay) |=> (!mu.mu_req || $stable(mu.mu_req_data)))
        else $error("miss request data changed while waiting for the miss unit");
endmodule

`default_nettype wire

// File: tb/tb_wt_dcache_miss_arb.sv
`default_nettype none
// ============================================================================
// Module: tb_wt_dcache_miss_arb
// Directed vector table, reset corner cases and randomized model comparison.
// Revision: 1.0
// ============================================================================

module tb_wt_dcache_miss_arb;
    import wt_cache_pkg::*;

    localparam int NP = 3;
    localparam logic [55:0] P0 = 56'h8000_0000;
    localparam logic [55:0] P1 = 56'h8000_1040;
    localparam logic [55:0] P2 = 56'h8000_2080;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NP-1:0]   miss_req;
    logic [NP-1:0]   ack_o, rep_o, rtrn_o;
    miss_req_t       req_data [NP];

    wt_dcache_miss_arb_if mu_if ();

    wt_dcache_miss_arb #(.NumPorts(NP)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .miss_req_i      (miss_req),
        .miss_req_data_i (req_data),
        .miss_ack_o      (ack_o),
        .miss_replay_o   (rep_o),
        .miss_rtrn_vld_o (rtrn_o),
        .mu              (mu_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  req;
        logic        ack, rep, rv;
        logic [3:0]  rid;
        logic        mq;
        logic [55:0] pa;
        logic [2:0]  ea, er, et, eo;
        logic [1:0]  ep;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic        m_busy;
    int          m_owner, m_ptr;
    logic [2:0]  m_out;
    logic [2:0]  e_ack, e_rep, e_rtrn;
    logic        e_mureq;
    miss_req_t   e_data;
    logic [2:0]  cur_req, last_ack;
    logic        a_r, rp_r, rv_r;
    logic [3:0]  id_r;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic a, input logic rp,
                         input logic rv, input logic [3:0] id);
        miss_req           = r;
        mu_if.mu_ack       = a;
        mu_if.mu_replay    = rp;
        mu_if.mu_rtrn_vld  = rv;
        mu_if.mu_rtrn_id   = id;
    endtask

    function automatic vec_t mk(input logic [2:0] req, input logic ack, input logic rep,
                                input logic rv, input logic [3:0] rid, input logic mq,
                                input logic [55:0] pa, input logic [2:0] ea, input logic [2:0] er,
                                input logic [2:0] et, input logic [2:0] eo, input logic [1:0] ep);
        vec_t v;
        v.req = req; v.ack = ack; v.rep = rep; v.rv = rv; v.rid = rid;
        v.mq = mq; v.pa = pa; v.ea = ea; v.er = er; v.et = et; v.eo = eo; v.ep = ep;
        return v;
    endfunction

    function automatic miss_req_t rand_data(input int p);
        miss_req_t d;
        d.paddr    = {$urandom(), $urandom()} & {8'h0, {48{1'b1}}};
        d.size     = 3'($urandom_range(0, 7));
        d.nc       = 1'($urandom_range(0, 1));
        d.vld_bits = 4'($urandom_range(0, 15));
        d.id       = 4'(p + 1);
        return d;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, " mu_req"},  128'(mu_if.mu_req), 128'(0));
        chk({tag, " mu_data"}, 128'(mu_if.mu_req_data), 128'(0));
        chk({tag, " ack"},     128'(ack_o), 128'(0));
        chk({tag, " replay"},  128'(rep_o), 128'(0));
        chk({tag, " rtrn"},    128'(rtrn_o), 128'(0));
        chk({tag, " outst"},   128'(dut.outstanding_q), 128'(0));
        chk({tag, " ptr"},     128'(dut.rr_ptr_q), 128'(0));
    endtask

    initial begin
        //        req    ack rep rv rid  mq pa  ack_o  rep_o  rtrn   outst  ptr
        vecs.push_back(mk(3'b010, 0, 0, 0, 0, 0, 0,  3'b000, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b010, 0, 0, 0, 0, 1, P1, 3'b000, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b010, 1, 0, 0, 0, 1, P1, 3'b010, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b100, 0, 0, 0, 0, 0, 0,  3'b000, 3'b000, 3'b000, 3'b010, 2));
        vecs.push_back(mk(3'b100, 1, 1, 0, 0, 1, P2, 3'b000, 3'b100, 3'b000, 3'b010, 2));
        vecs.push_back(mk(3'b101, 0, 0, 0, 0, 0, 0,  3'b000, 3'b000, 3'b000, 3'b010, 0));
        vecs.push_back(mk(3'b101, 1, 0, 0, 0, 1, P0, 3'b001, 3'b000, 3'b000, 3'b010, 0));
        vecs.push_back(mk(3'b100, 0, 0, 0, 0, 0, 0,  3'b000, 3'b000, 3'b000, 3'b011, 1));
        vecs.push_back(mk(3'b100, 1, 0, 0, 0, 1, P2, 3'b100, 3'b000, 3'b000, 3'b011, 1));
        vecs.push_back(mk(3'b000, 0, 0, 1, 1, 0, 0,  3'b000, 3'b000, 3'b001, 3'b111, 0));
        vecs.push_back(mk(3'b000, 0, 0, 1, 5, 0, 0,  3'b000, 3'b000, 3'b000, 3'b110, 0));
        vecs.push_back(mk(3'b000, 0, 0, 1, 1, 0, 0,  3'b000, 3'b000, 3'b000, 3'b110, 0));
        vecs.push_back(mk(3'b000, 0, 0, 1, 3, 0, 0,  3'b000, 3'b000, 3'b100, 3'b110, 0));
        vecs.push_back(mk(3'b000, 0, 0, 1, 2, 0, 0,  3'b000, 3'b000, 3'b010, 3'b010, 0));
        vecs.push_back(mk(3'b001, 0, 0, 0, 0, 0, 0,  3'b000, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b001, 1, 0, 0, 0, 1, P0, 3'b001, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b100, 0, 0, 0, 0, 0, 0,  3'b000, 3'b000, 3'b000, 3'b001, 1));
        vecs.push_back(mk(3'b000, 1, 0, 0, 0, 0, P2, 3'b000, 3'b000, 3'b000, 3'b001, 1));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0,  3'b000, 3'b000, 3'b000, 3'b001, 1));
        vecs.push_back(mk(3'b001, 0, 0, 0, 0, 0, 0,  3'b000, 3'b000, 3'b000, 3'b001, 1));
        vecs.push_back(mk(3'b001, 1, 0, 1, 1, 1, P0, 3'b001, 3'b000, 3'b001, 3'b001, 1));
        vecs.push_back(mk(3'b000, 0, 0, 1, 1, 0, 0,  3'b000, 3'b000, 3'b001, 3'b001, 1));
        vecs.push_back(mk(3'b000, 0, 0, 1, 1, 0, 0,  3'b000, 3'b000, 3'b000, 3'b000, 1));

        req_data[0] = '{paddr: P0, size: 3'd3, nc: 1'b0, vld_bits: 4'hf, id: 4'd1};
        req_data[1] = '{paddr: P1, size: 3'd3, nc: 1'b0, vld_bits: 4'hf, id: 4'd2};
        req_data[2] = '{paddr: P2, size: 3'd3, nc: 1'b1, vld_bits: 4'h3, id: 4'd3};

        // Inputs fully active while held in reset: nothing may leak out.
        drive(3'b111, 1'b1, 1'b1, 1'b1, 4'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        drive(3'b000, 1'b0, 1'b0, 1'b0, 4'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].req, vecs[i].ack, vecs[i].rep, vecs[i].rv, vecs[i].rid);
            @(negedge clk);
            chk($sformatf("vec%0d mu_req", i), 128'(mu_if.mu_req), 128'(vecs[i].mq));
            chk($sformatf("vec%0d paddr", i),  128'(mu_if.mu_req_data.paddr), 128'(vecs[i].pa));
            chk($sformatf("vec%0d ack", i),    128'(ack_o), 128'(vecs[i].ea));
            chk($sformatf("vec%0d replay", i), 128'(rep_o), 128'(vecs[i].er));
            chk($sformatf("vec%0d rtrn", i),   128'(rtrn_o), 128'(vecs[i].et));
            chk($sformatf("vec%0d outst", i),  128'(dut.outstanding_q), 128'(vecs[i].eo));
            chk($sformatf("vec%0d ptr", i),    128'(dut.rr_ptr_q), 128'(vecs[i].ep));
        end

        // Build outstanding 3'b011 with port 2 owning the bus, then reset mid-transaction.
        @(posedge clk); #1; drive(3'b010, 0, 0, 0, 0); @(negedge clk);
        @(posedge clk); #1; drive(3'b010, 1, 0, 0, 0); @(negedge clk);
        @(posedge clk); #1; drive(3'b001, 0, 0, 0, 0); @(negedge clk);
        @(posedge clk); #1; drive(3'b001, 1, 0, 0, 0); @(negedge clk);
        @(posedge clk); #1; drive(3'b100, 0, 0, 0, 0); @(negedge clk);
        @(posedge clk); #1; drive(3'b100, 0, 0, 0, 0); @(negedge clk);
        chk("pre-rst mu_req", 128'(mu_if.mu_req), 128'(1));
        chk("pre-rst outst",  128'(dut.outstanding_q), 128'(3'b011));
        #2;
        drive(3'b100, 1'b1, 1'b0, 1'b1, 4'd1);
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("async-rst");
        @(posedge clk);
        @(negedge clk);
        drive(3'b100, 0, 0, 0, 0);
        rst_ni = 1'b1;
        #1;
        chk("post-rst idle mu_req", 128'(mu_if.mu_req), 128'(0));
        @(negedge clk);
        chk("post-rst busy mu_req", 128'(mu_if.mu_req), 128'(1));
        chk("post-rst busy paddr",  128'(mu_if.mu_req_data.paddr), 128'(P2));

        // Randomized phase from a clean reset.
        @(posedge clk); #1;
        drive(3'b000, 0, 0, 0, 0);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_out = '0;
        cur_req = '0; last_ack = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (cur_req[p]) begin
                    if (last_ack[p] || $urandom_range(0, 19) == 0) cur_req[p] = 1'b0;
                end else if (!m_out[p] && $urandom_range(0, 2) == 0) begin
                    cur_req[p]  = 1'b1;
                    req_data[p] = rand_data(p);
                end
            end
            a_r  = ($urandom_range(0, 9) < 4);
            rp_r = ($urandom_range(0, 9) < 2);
            rv_r = ($urandom_range(0, 9) < 3);
            id_r = 4'($urandom_range(0, 4));
            drive(cur_req, a_r, rp_r, rv_r, id_r);
            @(negedge clk);

            e_mureq = m_busy && cur_req[m_owner];
            e_data  = m_busy ? req_data[m_owner] : '0;
            e_ack   = '0;
            e_rep   = '0;
            if (e_mureq) begin
                if (rp_r)     e_rep[m_owner] = 1'b1;
                else if (a_r) e_ack[m_owner] = 1'b1;
            end
            for (int p = 0; p < NP; p++)
                e_rtrn[p] = rv_r && m_out[p] && (id_r == req_data[p].id);

            chk("rnd mu_req",  128'(mu_if.mu_req), 128'(e_mureq));
            chk("rnd mu_data", 128'(mu_if.mu_req_data), 128'(e_data));
            chk("rnd ack",     128'(ack_o), 128'(e_ack));
            chk("rnd replay",  128'(rep_o), 128'(e_rep));
            chk("rnd rtrn",    128'(rtrn_o), 128'(e_rtrn));
            chk("rnd outst",   128'(dut.outstanding_q), 128'(m_out));

            m_out = (m_out & ~e_rtrn) | e_ack;
            if (m_busy) begin
                if (!cur_req[m_owner]) begin
                    m_busy = 1'b0;
                end else if ((e_ack | e_rep) != 0) begin
                    m_ptr  = (m_owner + 1) % NP;
                    m_busy = 1'b0;
                end
            end else if (cur_req != 0) begin
                for (int k = NP - 1; k >= 0; k--)
                    if (cur_req[(m_ptr + k) % NP]) m_owner = (m_ptr + k) % NP;
                m_busy = 1'b1;
            end
            last_ack = e_ack;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
